seq_alu: RTL

- Parametrised, iterative successor of the 16-bit ripple-carry ALU.
- Evaluates AND/OR/ADD/SLT, with operand inversion, over WIDTH bits, CHUNK bits per clock.
- A registered carry links the chunks from one cycle to the next.
- Valid/ready handshakes on input and output let it act as a multi-cycle execute unit behind the CPU's decode stage.

---
 rtl/seq_alu.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Iterative AND/OR/ADD/SLT unit: evaluates WIDTH-bit operands CHUNK bits per clock, linking the
// chunks through a registered carry, behind valid/ready handshakes on input and output.
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             invertA_i,
  input  logic             invertB_i,
  input  logic [1:0]       operation_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             cout_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  int unsigned      base_c;
  logic [CHUNK-1:0] a_c, b_c, chunk_c;
  logic [CHUNK:0]   sum_c;
  logic             arith_c, last_c, cin_msb_c, ovf_c, set_c;
  logic [WIDTH-1:0] res_next_c;

  always_comb begin
    base_c    = int'(cnt_q) * CHUNK;
    a_c       = a_q[base_c +: CHUNK];
    b_c       = b_q[base_c +: CHUNK];
    sum_c     = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    arith_c   = op_q[1];
    last_c    = (cnt_q == CW'(NCHUNK - 1));
    unique case (op_q)
      2'b00:   chunk_c = a_c & b_c;
      2'b01:   chunk_c = a_c | b_c;
      default: chunk_c = sum_c[CHUNK-1:0];
    endcase
    // Only meaningful on the last chunk, where bit CHUNK-1 is the word MSB.
    cin_msb_c = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1];
    ovf_c     = arith_c & (cin_msb_c ^ sum_c[CHUNK]);
    set_c     = sum_c[CHUNK-1] ^ ovf_c;
    res_next_c = result_o;
    res_next_c[base_c +: CHUNK] = chunk_c;
    if (last_c && (op_q == 2'b11)) begin
      res_next_c = {{(WIDTH-1){1'b0}}, set_c};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      overflow_o <= 1'b0;
      cout_o     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= src1_i ^ {WIDTH{invertA_i}};
            b_q      <= src2_i ^ {WIDTH{invertB_i}};
            op_q     <= operation_i;
            carry_q  <= invertB_i;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          result_o <= res_next_c;
          carry_q  <= sum_c[CHUNK];
          if (last_c) begin
            state_q    <= StDone;
            out_valid  <= 1'b1;
            zero_o     <= (res_next_c == '0);
            overflow_o <= ovf_c;
            cout_o     <= arith_c & sum_c[CHUNK];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
